// File: rtl/pack_stream.sv
// Packs LANES narrow elements into one OUT_W word behind a valid/ready port.
// Define PACK_SAT_EN to saturate signed inputs instead of truncating them.
module pack_stream #(
  parameter  int IN_W   = 24,
  parameter  int ELEM_W = 8,
  parameter  int LANES  = 4,
  localparam int OUT_W  = ELEM_W * LANES,
  localparam int CNT_W  = $clog2(LANES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   pack_q, pack_d;
  logic [CNT_W-1:0]   ptr_q, ptr_d;
  logic               pend_q, pend_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   wpack;
  logic [CNT_W-1:0]   wptr;
  logic [ELEM_W-1:0]  lane_val;
  logic               in_fire;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !out_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_data  = data_q;
  assign out_count = cnt_q;

`ifdef PACK_SAT_EN
  localparam logic [IN_W-1:0] SMAX =
    {{(IN_W-ELEM_W+1){1'b0}}, {(ELEM_W-1){1'b1}}};
  localparam logic [IN_W-1:0] SMIN =
    {{(IN_W-ELEM_W+1){1'b1}}, {(ELEM_W-1){1'b0}}};

  always_comb begin
    lane_val = in_data[ELEM_W-1:0];
    if ($signed(in_data) > $signed(SMAX))
      lane_val = {1'b0, {(ELEM_W-1){1'b1}}};
    else if ($signed(in_data) < $signed(SMIN))
      lane_val = {1'b1, {(ELEM_W-1){1'b0}}};
  end
`else
  assign lane_val = in_data[ELEM_W-1:0];

  if (IN_W > ELEM_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^in_data[IN_W-1:ELEM_W];
  end
`endif

  // In HOLD the buffer and pointer are already zero, so the same
  // write path lands a concurrent element in lane 0.
  always_comb begin
    wpack = pack_q;
    wptr  = ptr_q;
    if (in_fire) begin
      for (int i = 0; i < LANES; i++)
        if (ptr_q == CNT_W'(i))
          wpack[i*ELEM_W +: ELEM_W] = lane_val;
      wptr = ptr_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    pack_d  = pack_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = FILL;
      pack_d  = '0;
      ptr_d   = '0;
      pend_d  = 1'b0;
      data_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          pend_d = 1'b0;
          if (wptr == CNT_W'(LANES) ||
              ((flush | pend_q) && wptr != '0)) begin
            state_d = HOLD;
            data_d  = wpack;
            cnt_d   = wptr;
            pack_d  = '0;
            ptr_d   = '0;
          end else begin
            pack_d = wpack;
            ptr_d  = wptr;
          end
        end
        HOLD: begin
          pend_d = pend_q | flush;
          if (out_ready) begin
            state_d = FILL;
            data_d  = '0;
            cnt_d   = '0;
            pack_d  = wpack;
            ptr_d   = wptr;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      pack_q  <= '0;
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pack_q  <= pack_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
